// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode constants, scoreboard entry payload and helpers for the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Widest supported latency counter; per-instance counters are zero-extended to this.
  localparam int unsigned SB_CNT_W = 8;

  typedef struct packed {
    logic                pending;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

  // A latency of zero is treated as a single cycle.
  function automatic logic [SB_CNT_W-1:0] eff_latency(input logic [SB_CNT_W-1:0] lat);
    return (lat == '0) ? SB_CNT_W'(1) : lat;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// Single-register pending flag with result countdown.
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             set_en,
  input  logic [LAT_W-1:0] set_cnt,
  output sb_entry_t        entry
);

  logic             pending_q, pending_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Count down while the pipeline advances; a new writer overrides the countdown.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (!hold && pending_q) begin
      cnt_d = cnt_q - LAT_W'(1);
      if (cnt_q == LAT_W'(1)) begin
        pending_d = 1'b0;
      end
    end
    if (set_en) begin
      pending_d = 1'b1;
      cnt_d     = set_cnt;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Present the entry zero-extended to the shared payload width.
  always_comb begin
    entry.pending = pending_q;
    entry.cnt     = SB_CNT_W'(cnt_q);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: RAW/WAW stall detection, bypass selection, flush control and stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned LAT_W      = 3,
  parameter int unsigned FWD_WINDOW = 1,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [6:0]                  id_opcode,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
  input  logic                        id_rs1_used,
  input  logic                        id_rs2_used,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd,
  input  logic                        id_reg_wr_en,
  input  logic [LAT_W-1:0]            id_latency,
  input  logic                        ex_busy,
  input  logic                        branch_taken,
  output logic                        stall_if,
  output logic                        stall_id,
  output logic                        flush_branch,
  output logic                        flush_jump,
  output logic                        fwd_rs1,
  output logic                        fwd_rs2,
  output logic [PERF_W-1:0]           stall_cycles
);

  localparam int unsigned         RW      = $clog2(NUM_REGS);
  localparam logic [SB_CNT_W-1:0] FWD_LIM = SB_CNT_W'(FWD_WINDOW);

  sb_entry_t entries [NUM_REGS];

  logic             wr_issue;
  logic [LAT_W-1:0] lat_eff;

  // x0 is hardwired and never tracked.
  assign entries[0] = '0;

  // One countdown cell per writable architectural register.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .hold    (ex_busy),
      .set_en  (wr_issue && (id_rd == RW'(r))),
      .set_cnt (lat_eff),
      .entry   (entries[r])
    );
  end

  sb_entry_t e_rs1, e_rs2, e_rd;
  logic      raw_1, raw_2, waw, stall, issue;

  // Hazard, bypass and flush decisions, all taken on pre-issue state.
  always_comb begin
    e_rs1    = entries[id_rs1];
    e_rs2    = entries[id_rs2];
    e_rd     = entries[id_rd];
    lat_eff  = (id_latency == '0) ? LAT_W'(1) : id_latency;
    raw_1    = id_valid && id_rs1_used && e_rs1.pending && (e_rs1.cnt > FWD_LIM);
    raw_2    = id_valid && id_rs2_used && e_rs2.pending && (e_rs2.cnt > FWD_LIM);
    fwd_rs1  = id_valid && id_rs1_used && e_rs1.pending && (e_rs1.cnt <= FWD_LIM);
    fwd_rs2  = id_valid && id_rs2_used && e_rs2.pending && (e_rs2.cnt <= FWD_LIM);
    waw      = id_valid && id_reg_wr_en && (id_rd != '0) && e_rd.pending &&
               (e_rd.cnt > eff_latency(SB_CNT_W'(id_latency)));
    stall    = (raw_1 || raw_2 || waw || ex_busy) && !branch_taken;
    issue    = id_valid && !stall && !branch_taken;
    wr_issue = issue && id_reg_wr_en && (id_rd != '0);
    stall_id     = stall;
    stall_if     = stall;
    flush_branch = branch_taken;
    flush_jump   = id_valid && (id_opcode == OP_JAL) && !stall && !branch_taken;
  end

  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {PERF_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  // Stall counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench for hazard_scoreboard against a countdown-array reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned NREG = 32;
  localparam int unsigned LW   = 3;
  localparam int unsigned FWD  = 1;
  localparam int unsigned PW   = 6;
  localparam int unsigned RW   = 5;
  localparam int          PMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [6:0]    id_opcode;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used, id_reg_wr_en;
  logic [LW-1:0] id_latency;
  logic          ex_busy, branch_taken;
  logic          stall_if, stall_id, flush_branch, flush_jump, fwd_rs1, fwd_rs2;
  logic [PW-1:0] stall_cycles;

  hazard_scoreboard #(
    .NUM_REGS   (NREG),
    .LAT_W      (LW),
    .FWD_WINDOW (FWD),
    .PERF_W     (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_wr_en (id_reg_wr_en),
    .id_latency   (id_latency),
    .ex_busy      (ex_busy),
    .branch_taken (branch_taken),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_branch (flush_branch),
    .flush_jump   (flush_jump),
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          stall_if;
    logic          stall_id;
    logic          flush_branch;
    logic          flush_jump;
    logic          fwd_rs1;
    logic          fwd_rs2;
    logic [PW-1:0] perf;
  } obs_t;

  // Reference model: cycles remaining until each register's result lands (0 = none pending).
  int   rem [NREG];
  int   perf_m;
  obs_t expq [$];
  int   total;
  int   bad;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one ID-stage cycle, queue the model's expected response and advance the model.
  task automatic step(input bit chk, input bit r, input bit v, input logic [6:0] op,
                      input int s1, input bit u1, input int s2, input bit u2,
                      input int d, input bit w, input int lat, input bit busy, input bit br);
    obs_t e;
    int   le;
    bit   raw1, raw2, waw, st;
    @(posedge clk);
    #1;
    rst          = r;
    id_valid     = v;
    id_opcode    = op;
    id_rs1       = RW'(s1);
    id_rs1_used  = u1;
    id_rs2       = RW'(s2);
    id_rs2_used  = u2;
    id_rd        = RW'(d);
    id_reg_wr_en = w;
    id_latency   = LW'(lat);
    ex_busy      = busy;
    branch_taken = br;
    le   = (lat == 0) ? 1 : lat;
    raw1 = v && u1 && (rem[s1] > FWD);
    raw2 = v && u2 && (rem[s2] > FWD);
    waw  = v && w && (d != 0) && (rem[d] > le);
    st   = (raw1 || raw2 || waw || busy) && !br;
    e.stall_if     = st;
    e.stall_id     = st;
    e.flush_branch = br;
    e.flush_jump   = v && (op == OP_JAL) && !st && !br;
    e.fwd_rs1      = v && u1 && (rem[s1] > 0) && (rem[s1] <= FWD);
    e.fwd_rs2      = v && u2 && (rem[s2] > 0) && (rem[s2] <= FWD);
    e.perf         = PW'(perf_m);
    if (chk) expq.push_back(e);
    if (r) begin
      foreach (rem[i]) rem[i] = 0;
      perf_m = 0;
    end else begin
      if (st && perf_m < PMAX) perf_m++;
      if (!busy) foreach (rem[i]) if (rem[i] > 0) rem[i]--;
      if (v && !st && !br && w && d != 0) rem[d] = le;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp("stall_id", int'(stall_id), int'(e.stall_id));
        cmp("stall_if", int'(stall_if), int'(e.stall_if));
        cmp("flush", int'({flush_branch, flush_jump}), int'({e.flush_branch, e.flush_jump}));
        cmp("fwd", int'({fwd_rs1, fwd_rs2}), int'({e.fwd_rs1, e.fwd_rs2}));
        cmp("stall_cycles", int'(stall_cycles), int'(e.perf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    perf_m = 0;
    foreach (rem[i]) rem[i] = 0;
    {rst, id_valid, id_rs1_used, id_rs2_used, id_reg_wr_en, ex_busy, branch_taken} = '0;
    id_opcode = OP_ALU; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_latency = '0;

    step(0, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // RAW on x5: stall until the result is within the bypass window, then forward.
    step(1, 0, 1, OP_ALU, 1, 1, 2, 1, 5, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, OP_ALU, 5, 1, 0, 0, 6, 0, 1, 0, 0);
    idle(4);

    // WAW on x7: younger short-latency writer waits for the older one.
    step(1, 0, 1, OP_ALU, 0, 0, 0, 0, 7, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, OP_ALU, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 0, 1, OP_ALU, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    idle(4);

    // Branch squash overrides a RAW stall and must not write the scoreboard.
    step(1, 0, 1, OP_ALU, 0, 0, 0, 0, 5, 1, 4, 0, 0);
    step(1, 0, 1, OP_ALU, 5, 1, 0, 0, 8, 1, 7, 0, 1);
    step(1, 0, 1, OP_ALU, 5, 1, 8, 1, 0, 0, 0, 0, 0);
    idle(5);

    // Frozen pipeline holds x9's countdown.
    step(1, 0, 1, OP_ALU, 0, 0, 0, 0, 9, 1, 3, 0, 0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, OP_ALU, 0, 0, 9, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, OP_ALU, 9, 1, 0, 0, 0, 0, 0, 0, 0);

    // JAL decode, and an x0 writer that must never become pending.
    step(1, 0, 1, OP_JAL, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    step(1, 0, 1, OP_ALU, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    idle(2);

    // Reset with several registers pending.
    step(1, 0, 1, OP_ALU, 0, 0, 0, 0, 1, 1, 7, 0, 0);
    step(1, 0, 1, OP_ALU, 0, 0, 0, 0, 2, 1, 7, 0, 0);
    step(1, 0, 1, OP_ALU, 0, 0, 0, 0, 3, 1, 7, 0, 0);
    step(1, 1, 1, OP_ALU, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, OP_ALU, 1, 1, 3, 1, 0, 0, 0, 0, 0);

    // Drive the stall counter into saturation.
    for (int i = 0; i < PMAX + 6; i++) step(1, 0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Random traffic over a small register pool to provoke frequent hazards.
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 4) == 0) ? OP_JAL : 7'($urandom);
      step(1, ($urandom_range(0, 399) == 0), ($urandom_range(0, 9) != 0), op,
           int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0));
    end

    repeat (2) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
